// File: rtl/layer_out_serializer.sv
// Collects one result per neuron into capture registers, then streams the whole
// vector element by element from a separate buffer so capture and streaming overlap.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic                              overrun,
  output logic                              busy
);

  localparam int IW = $clog2(NUM_NEURONS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_NEURONS-1:0]  flag_q, flag_d;
  logic [DATA_WIDTH-1:0]   cap_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   cap_d [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   buf_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   buf_d [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, busy_d;
  logic                    all_set, at_last, transfer;

  always_comb begin
    all_set  = &flag_q;
    at_last  = (state_q == STREAM) && (idx_q == IW'(NUM_NEURONS - 1));
    // A full capture set moves to the buffer when idle or as the last element leaves.
    transfer = all_set && ((state_q == IDLE) || at_last);

    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;
    flag_d      = transfer ? '0 : flag_q;

    for (int i = 0; i < NUM_NEURONS; i++) begin
      cap_d[i] = cap_q[i];
      buf_d[i] = transfer ? cap_q[i] : buf_q[i];
      // A capture on the transfer edge lands in the freshly emptied slot.
      if (in_valid[i]) begin
        if (!flag_q[i] || transfer) begin
          cap_d[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          flag_d[i] = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (transfer) begin
      state_d     = STREAM;
      idx_d       = '0;
      out_data_d  = cap_q[0];
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
    end else if (state_q == STREAM) begin
      if (at_last) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        idx_d      = idx_q + 1'b1;
        out_data_d = buf_q[idx_d];
        out_last_d = (idx_d == IW'(NUM_NEURONS - 1));
      end
    end

    busy_d = (|flag_d) || (state_d == STREAM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      flag_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flag_q      <= flag_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Data storage carries no reset; the flags decide what is meaningful.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
    buf_q <= buf_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with NUM_NEURONS=4, DATA_WIDTH=16.
module tb_layer_out_serializer;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        overrun;
  logic        busy;

  int tests;
  int fails;
  logic [19:0] got;
  logic [19:0] exp;

  layer_out_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(logic [15:0] d3, logic [15:0] d2,
                                     logic [15:0] d1, logic [15:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Sampled word layout: {out_valid, out_last, overrun, busy, out_data}.
  task automatic sample;
    got = {out_valid, out_last, overrun, busy, out_data};
  endtask

  task automatic test_reset;
    #12;
    sample();
    tests++;
    if (got !== 20'h0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", got, 20'h0);
    end
    #1 rst = 1'b1;
    cyc();
    sample();
    tests++;
    if (got !== 20'h0) begin
      fails++;
      $display("FAIL reset_idle got=%h exp=%h", got, 20'h0);
    end
  endtask

  task automatic test_single;
    in_valid = 4'b1111;
    in_data  = pk(16'h0004, 16'h0003, 16'h0002, 16'h0001);
    cyc();
    in_valid = 4'b0000;
    sample();
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL single_captured got=%h exp=%h", got, exp);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      exp = {1'b1, (k == 3), 1'b0, 1'b1, 16'(k + 1)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL single_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
    sample();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0004};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL single_done got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_staggered;
    logic [3:0]  order_v [4];
    logic [15:0] elem [4];
    order_v[0] = 4'b0100; order_v[1] = 4'b0001;
    order_v[2] = 4'b1000; order_v[3] = 4'b0010;
    elem[0] = 16'h000A; elem[1] = 16'h000B; elem[2] = 16'h000C; elem[3] = 16'h000D;
    for (int s = 0; s < 4; s++) begin
      in_valid = order_v[s];
      in_data  = 64'hEEEE_EEEE_EEEE_EEEE;
      for (int i = 0; i < 4; i++)
        if (order_v[s][i]) in_data[i*16 +: 16] = elem[i];
      cyc();
      in_valid = 4'b0000;
      sample();
      tests++;
      if (got[19] !== 1'b0 || got[16] !== 1'b1) begin
        fails++;
        $display("FAIL stagger_wait%0d got=%h exp valid=0 busy=1", s, got);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      exp = {1'b1, (k == 3), 1'b0, 1'b1, elem[k]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL stagger_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
  endtask

  task automatic test_back_to_back;
    in_valid = 4'b1111;
    in_data  = pk(16'h0014, 16'h0013, 16'h0012, 16'h0011);
    cyc();
    in_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) begin
        in_valid = 4'b1111;
        in_data  = pk(16'h0024, 16'h0023, 16'h0022, 16'h0021);
      end else begin
        in_valid = 4'b0000;
      end
      sample();
      exp = {1'b1, (k == 3 || k == 7), 1'b0, 1'b1,
             (k < 4) ? 16'(16'h0011 + k) : 16'(16'h0021 + k - 4)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
    sample();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0024};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_done got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_capture_on_transfer;
    logic [15:0] elem [4];
    in_valid = 4'b1111;
    in_data  = pk(16'h0034, 16'h0033, 16'h0032, 16'h0031);
    cyc();
    in_valid = 4'b0001;
    in_data  = pk(16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h00AA);
    for (int k = 0; k < 4; k++) begin
      cyc();
      in_valid = 4'b0000;
      sample();
      exp = {1'b1, (k == 3), 1'b0, 1'b1, 16'(16'h0031 + k)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL cot_first_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
    sample();
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0034};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cot_flag_held got=%h exp=%h", got, exp);
    end
    in_valid = 4'b1110;
    in_data  = pk(16'h0043, 16'h0042, 16'h0041, 16'hEEEE);
    cyc();
    in_valid = 4'b0000;
    elem[0] = 16'h00AA; elem[1] = 16'h0041; elem[2] = 16'h0042; elem[3] = 16'h0043;
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      exp = {1'b1, (k == 3), 1'b0, 1'b1, elem[k]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL cot_next_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
  endtask

  task automatic test_overrun;
    logic [15:0] elem [4];
    in_valid = 4'b0010;
    in_data  = pk(16'hEEEE, 16'hEEEE, 16'h1111, 16'hEEEE);
    cyc();
    in_data  = pk(16'hEEEE, 16'hEEEE, 16'h2222, 16'hEEEE);
    cyc();
    sample();
    tests++;
    if (got[17] !== 1'b1 || got[19] !== 1'b0) begin
      fails++;
      $display("FAIL overrun_set got=%h exp overrun=1 valid=0", got);
    end
    in_valid = 4'b1101;
    in_data  = pk(16'h4000, 16'h3000, 16'hEEEE, 16'h1000);
    cyc();
    in_valid = 4'b0000;
    elem[0] = 16'h1000; elem[1] = 16'h1111; elem[2] = 16'h3000; elem[3] = 16'h4000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      exp = {1'b1, (k == 3), 1'b1, 1'b1, elem[k]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL overrun_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h4000};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL overrun_sticky got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid_stream;
    in_valid = 4'b1111;
    in_data  = pk(16'h0054, 16'h0053, 16'h0052, 16'h0051);
    cyc();
    in_valid = 4'b0000;
    cyc();
    cyc();
    cyc();
    sample();
    exp = {1'b1, 1'b0, 1'b1, 1'b1, 16'h0053};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL midrst_elem2 got=%h exp=%h", got, exp);
    end
    #2 rst = 1'b0;
    #1;
    sample();
    tests++;
    if (got !== 20'h0) begin
      fails++;
      $display("FAIL midrst_async got=%h exp=%h", got, 20'h0);
    end
    rst = 1'b1;
    in_valid = 4'b1111;
    in_data  = pk(16'h0064, 16'h0063, 16'h0062, 16'h0061);
    cyc();
    in_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      exp = {1'b1, (k == 3), 1'b0, 1'b1, 16'(16'h0061 + k)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL midrst_elem%0d got=%h exp=%h", k, got, exp);
      end
    end
    cyc();
    sample();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0064};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL midrst_done got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    in_valid = 4'b0000;
    in_data  = 64'h0;
    test_reset();
    test_single();
    test_staggered();
    test_back_to_back();
    test_capture_on_transfer();
    test_overrun();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
